spi_target: RTL and testbench

SPI target (slave) endpoint that answers the team's `spi_core` initiator on the same four-wire bus and uses the same wire timing. The block oversamples `sclk`, `ss_n` and `mosi` in the system clock domain and drives `miso` from a transmit shift register. It exposes a byte-wide parallel side: a one-entry transmit holding buffer with a valid/ready handshake, and a received-byte register with a valid/ready handshake. It sits between the pad ring and a local register file or command decoder.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_in_sync.sv | 53 +++++
 rtl/spi_target.sv | 163 ++++++++++++++++
 tb/tb_spi_target.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI target: synchronizer depth, FSM encoding and idle fill.
package spi_pkg;

    localparam int unsigned SYNC_DEPTH = 2;

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_ACTIVE    = 2'd2;

    // Bit replicated across the frame width to form the default idle word.
    localparam logic IDLE_FILL = 1'b1;

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer with optional registered rise/fall strobes.
module spi_in_sync
    import spi_pkg::*;
#(
    parameter bit EDGES = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_DEPTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_DEPTH-1];

    generate
        if (EDGES) begin : g_edges
            logic prev_q;
            logic rise_q;
            logic fall_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prev_q <= 1'b0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    prev_q <= q_o;
                    rise_q <= q_o & ~prev_q;
                    fall_q <= ~q_o & prev_q;
                end
            end

            assign rise_o = rise_q;
            assign fall_o = fall_q;
        end else begin : g_no_edges
            assign rise_o = 1'b0;
            assign fall_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_target.sv
// SPI target endpoint (mode 0): oversampled bus, one-entry TX holding buffer, RX register.
module spi_target
    import spi_pkg::*;
#(
    parameter int unsigned         DWIDTH    = 8,
    parameter logic [DWIDTH-1:0]   IDLE_WORD = {DWIDTH{IDLE_FILL}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DWIDTH-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              frame_abort,
    input  logic              clr,
    output logic              busy
);

    localparam int unsigned    CW   = $clog2(DWIDTH);
    localparam logic [CW-1:0]  LAST = CW'(DWIDTH - 1);

    logic sclk_unused_lvl, sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_s, mosi_unused_rise, mosi_unused_fall;

    spi_in_sync #(.EDGES(1'b1)) u_sclk_sync (
        .clk(clk), .rst(rst), .d_i(sclk),
        .q_o(sclk_unused_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_in_sync #(.EDGES(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .d_i(ss_n),
        .q_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    spi_in_sync #(.EDGES(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .d_i(mosi),
        .q_o(mosi_s), .rise_o(mosi_unused_rise), .fall_o(mosi_unused_fall)
    );

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-2:0] rx_sh_q, rx_sh_d;
    logic [DWIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DWIDTH-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic [DWIDTH-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic              abort_q, abort_d;

    logic reload, word_done, accept, take;

    assign accept = tx_valid & ~buf_full_q;
    assign take   = rx_valid_q & rx_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        buf_d      = buf_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        abort_d    = 1'b0;
        reload     = 1'b0;
        word_done  = 1'b0;

        case (state_q)
            ST_WAIT_IDLE: begin
                if (ss_lvl) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    reload  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    abort_d = (cnt_q != '0);
                end else begin
                    if (sclk_rise) begin
                        rx_sh_d = {rx_sh_q[DWIDTH-3:0], mosi_s};
                        if (cnt_q == LAST) begin
                            word_done = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    // A falling edge seen with the counter at zero closes a word.
                    if (sclk_fall) begin
                        if (cnt_q == '0) reload = 1'b1;
                        else tx_sh_d = {tx_sh_q[DWIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase

        if (reload) tx_sh_d = buf_full_q ? buf_q : IDLE_WORD;
        buf_full_d = (buf_full_q & ~reload) | accept;
        if (accept) buf_d = tx_data;

        if (clr) overrun_d = 1'b0;
        if (word_done) begin
            rx_data_d  = {rx_sh_q, mosi_s};
            rx_valid_d = 1'b1;
            if (rx_valid_q & ~rx_ready) overrun_d = 1'b1;
        end else if (take) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT_IDLE;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            abort_q    <= abort_d;
        end
    end

    assign miso        = tx_sh_q[DWIDTH-1];
    assign busy        = (state_q == ST_ACTIVE);
    assign miso_oe     = busy;
    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = overrun_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target driven by a mode-0 initiator model at sclk = clk/10.
module tb_spi_target;

    logic       clk = 1'b0;
    logic       rst, sclk, ss_n, mosi, tx_valid, rx_ready, clr;
    logic [7:0] tx_data;
    logic       miso, miso_oe, tx_ready, rx_valid, rx_overrun, frame_abort, busy;
    logic [7:0] rx_data;

    spi_target #(.DWIDTH(8)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .frame_abort(frame_abort), .clr(clr), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] got_miso[$];
    int   rx_evt = 0;
    int   abort_cyc = 0;
    logic rx_valid_prev = 1'b0;
    bit   inj_en = 1'b0;
    int   inj_bit = 0;
    logic [7:0] inj_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    // Monitor: pops expectations whenever the DUT hands over a word.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) fail_now("rx_unexpected");
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (rx_valid && !rx_valid_prev) rx_evt++;
            rx_valid_prev = rx_valid;
            if (frame_abort) abort_cyc++;
            while (got_miso.size() > 0) begin
                if (exp_miso.size() == 0) begin
                    fail_now("miso_unexpected");
                    void'(got_miso.pop_front());
                end else begin
                    check("miso_word", got_miso.pop_front(), exp_miso.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic hp();
        repeat (5) @(negedge clk);
    endtask

    task automatic clock_bits(input int nbits, input logic [23:0] words, input bit rec);
        logic [7:0] got;
        got  = '0;
        mosi = words[23];
        hp();
        for (int b = 0; b < nbits; b++) begin
            sclk = 1'b1;
            got  = {got[6:0], miso};
            hp();
            sclk = 1'b0;
            if ((b % 8 == 7) && rec) got_miso.push_back(got);
            if (b + 1 < nbits) mosi = words[23-(b+1)];
            if (inj_en && b == inj_bit) begin
                // Land tx_valid on the cycle the target reloads after this fall.
                repeat (3) @(negedge clk);
                check("inj_tx_ready", tx_ready, 1);
                tx_data  = inj_data;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                @(negedge clk);
                inj_en = 1'b0;
            end else begin
                hp();
            end
        end
    endtask

    task automatic spi_frame(input int nbits, input logic [23:0] words);
        ss_n = 1'b0;
        clock_bits(nbits, words, 1'b1);
        check("busy_in_frame", busy, 1);
        check("miso_oe_in_frame", miso_oe, 1);
        ss_n = 1'b1;
        hp();
        hp();
        check("busy_after_frame", busy, 0);
    endtask

    task automatic push_tx(input logic [7:0] d);
        int t;
        t = 0;
        while (!tx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) check("tx_ready_timeout", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        int a0, e0;
        rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b1; clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_overrun", rx_overrun, 0);
        check("rst_abort", frame_abort, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single word, both directions.
        push_tx(8'hA5);
        check("tx_ready_after_push", tx_ready, 0);
        exp_rx.push_back(8'h3C);
        exp_miso.push_back(8'hA5);
        spi_frame(8, 24'h3C0000);

        // Three words: buffered, refilled mid-frame, then idle fill.
        push_tx(8'h11);
        exp_miso.push_back(8'h11); exp_miso.push_back(8'h22); exp_miso.push_back(8'hFF);
        exp_rx.push_back(8'h81); exp_rx.push_back(8'h42); exp_rx.push_back(8'h24);
        e0 = rx_evt;
        fork
            spi_frame(24, 24'h814224);
            push_tx(8'h22);
        join
        repeat (4) @(negedge clk);
        check("three_rx_events", rx_evt - e0, 3);

        // Overrun with consumer stalled.
        rx_ready = 1'b0;
        exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF);
        spi_frame(16, 24'h5AC300);
        check("ovr_rx_valid", rx_valid, 1);
        check("ovr_rx_data", rx_data, 8'hC3);
        check("ovr_flag", rx_overrun, 1);
        exp_rx.push_back(8'hC3);
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ovr_taken", rx_valid, 0);
        check("ovr_sticky", rx_overrun, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("ovr_cleared", rx_overrun, 0);

        // Partial word aborted, then a clean frame.
        a0 = abort_cyc;
        e0 = rx_evt;
        spi_frame(5, 24'hF00000);
        check("abort_pulse_cycles", abort_cyc - a0, 1);
        check("abort_no_rx", rx_evt - e0, 0);
        push_tx(8'h96);
        exp_miso.push_back(8'h96);
        exp_rx.push_back(8'h69);
        spi_frame(8, 24'h690000);

        // Reset mid-frame, clocking continues with ss_n still low.
        e0 = rx_evt;
        ss_n = 1'b0;
        clock_bits(3, 24'hA00000, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_miso_oe", miso_oe, 0);
        check("midrst_miso", miso, 0);
        check("midrst_tx_ready", tx_ready, 1);
        check("midrst_rx_valid", rx_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        clock_bits(8, 24'hFF0000, 1'b0);
        check("midrst_still_idle", busy, 0);
        check("midrst_no_rx", rx_evt - e0, 0);
        ss_n = 1'b1;
        hp();
        hp();
        push_tx(8'h3A);
        exp_miso.push_back(8'h3A);
        exp_rx.push_back(8'hE7);
        spi_frame(8, 24'hE70000);

        // Handshake coinciding with the end-of-word reload.
        push_tx(8'h5C);
        inj_en = 1'b1; inj_bit = 7; inj_data = 8'hB4;
        exp_miso.push_back(8'h5C); exp_miso.push_back(8'hFF); exp_miso.push_back(8'hB4);
        exp_rx.push_back(8'h01); exp_rx.push_back(8'h80); exp_rx.push_back(8'hFF);
        spi_frame(24, 24'h0180FF);
        check("inj_buffer_drained", tx_ready, 1);

        repeat (20) @(negedge clk);
        check("rx_queue_empty", exp_rx.size(), 0);
        check("miso_queue_empty", exp_miso.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
